keypad_entry_accum: RTL and testbench

//  Consumes the 4-bit registered key code from the keypad scan/decode stage (0x0-0x9 digits,
//  0xA/0xB/0xC operator keys, 0xD '*', 0xE '#', 0xF no key).

---
 rtl/keypad_entry_accum.sv | 114 +++++++++++
 tb/tb_keypad_entry_accum.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_accum.sv
// Keypad entry accumulator: debounces scanned key codes, accepts each press once,
// and edits a BCD entry buffer, emitting committed numbers and operator events.
module keypad_entry_accum #(
   parameter int DIGITS        = 3,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [3:0]                   sample,
   output logic                         key_strobe,
   output logic [3:0]                   key_code,
   output logic [4*DIGITS-1:0]          entry_bcd,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count,
   output logic                         number_valid,
   output logic [4*DIGITS-1:0]          number_bcd,
   output logic                         op_valid,
   output logic [1:0]                   op_code,
   output logic                         overflow
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int DW = 4 * DIGITS;
   localparam int NW = $clog2(DIGITS + 1);

   typedef enum logic {IDLE, HELD} state_t;

   state_t         state;
   logic [3:0]     cand_p0;
   logic [CW-1:0]  cnt_p0;
   logic [CW-1:0]  cnt_nxt;
   logic           stable_nxt;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      if (c >= CW'(STABLE_CYCLES))
         return CW'(STABLE_CYCLES);
      return c + CW'(1);
   endfunction

   function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] buf_in, input logic [3:0] d);
      logic [DW-1:0] r;
      r      = buf_in << 4;
      r[3:0] = d;
      return r;
   endfunction

   // Qualifier stage: stable_nxt is true on the edge where the run of matching samples
   // reaches STABLE_CYCLES (and stays true while it saturates).
   always_comb begin
      cnt_nxt    = (sample == cand_p0) ? sat_inc(cnt_p0) : CW'(1);
      stable_nxt = (cnt_nxt == CW'(STABLE_CYCLES));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cand_p0      <= 4'hF;
         cnt_p0       <= '0;
         key_strobe   <= 1'b0;
         key_code     <= 4'h0;
         entry_bcd    <= '0;
         digit_count  <= '0;
         number_valid <= 1'b0;
         number_bcd   <= '0;
         op_valid     <= 1'b0;
         op_code      <= 2'b00;
         overflow     <= 1'b0;
      end else begin
         cand_p0      <= sample;
         cnt_p0       <= cnt_nxt;
         key_strobe   <= 1'b0;
         number_valid <= 1'b0;
         op_valid     <= 1'b0;
         overflow     <= 1'b0;
         case (state)
            IDLE: begin
               if (stable_nxt && sample != 4'hF) begin
                  state      <= HELD;
                  key_strobe <= 1'b1;
                  key_code   <= sample;
                  if (sample <= 4'h9) begin
                     if (digit_count < NW'(DIGITS)) begin
                        entry_bcd   <= shift_in(entry_bcd, sample);
                        digit_count <= digit_count + NW'(1);
                     end else begin
                        overflow <= 1'b1;
                     end
                  end else if (sample <= 4'hC || sample == 4'hE) begin
                     // Operators and '#' both commit a non-empty buffer.
                     if (sample <= 4'hC) begin
                        op_valid <= 1'b1;
                        op_code  <= 2'(sample - 4'h9);
                     end
                     if (digit_count != '0) begin
                        number_bcd   <= entry_bcd;
                        number_valid <= 1'b1;
                        entry_bcd    <= '0;
                        digit_count  <= '0;
                     end
                  end else begin
                     entry_bcd   <= '0;
                     digit_count <= '0;
                  end
               end
            end
            HELD: begin
               if (stable_nxt && sample == 4'hF)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_entry_accum.sv
// Self-checking bench for keypad_entry_accum: table of key presses with expected
// results pushed to a scoreboard queue and compared whenever key_strobe fires.
module tb_keypad_entry_accum;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  sample;
   logic        key_strobe;
   logic [3:0]  key_code;
   logic [11:0] entry_bcd;
   logic [1:0]  digit_count;
   logic        number_valid;
   logic [11:0] number_bcd;
   logic        op_valid;
   logic [1:0]  op_code;
   logic        overflow;

   keypad_entry_accum #(.DIGITS(3), .STABLE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .sample(sample),
      .key_strobe(key_strobe), .key_code(key_code),
      .entry_bcd(entry_bcd), .digit_count(digit_count),
      .number_valid(number_valid), .number_bcd(number_bcd),
      .op_valid(op_valid), .op_code(op_code), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  code;
      logic [11:0] entry;
      logic [1:0]  cnt;
      logic        nv;
      logic [11:0] nbcd;
      logic        opv;
      logic [1:0]  opc;
      logic        ov;
   } exp_t;

   exp_t q[$];
   exp_t tbl[19];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   cyc = 0;
   int   strobe_cyc = -1;
   int   drive_cyc;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Scoreboard: every accepted press must match the head of the queue.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (key_strobe === 1'b1) begin
            strobe_cyc = cyc;
            if (q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_strobe: got code %0h expected no strobe (t=%0t)", key_code, $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("key_code", {28'd0, key_code}, {28'd0, e.code});
               check("entry_bcd", {20'd0, entry_bcd}, {20'd0, e.entry});
               check("digit_count", {30'd0, digit_count}, {30'd0, e.cnt});
               check("number_valid", {31'd0, number_valid}, {31'd0, e.nv});
               check("number_bcd", {20'd0, number_bcd}, {20'd0, e.nbcd});
               check("op_valid", {31'd0, op_valid}, {31'd0, e.opv});
               check("op_code", {30'd0, op_code}, {30'd0, e.opc});
               check("overflow", {31'd0, overflow}, {31'd0, e.ov});
            end
         end else begin
            check("stray_pulse", {29'd0, number_valid, op_valid, overflow}, 32'd0);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input exp_t e);
      q.push_back(e);
      sample = e.code;
      step(10);
      sample = 4'hF;
      step(10);
      check("strobe_consumed", q.size(), 0);
   endtask

   task automatic check_all_zero();
      check("rst_key_strobe", {31'd0, key_strobe}, 32'd0);
      check("rst_key_code", {28'd0, key_code}, 32'd0);
      check("rst_entry_bcd", {20'd0, entry_bcd}, 32'd0);
      check("rst_digit_count", {30'd0, digit_count}, 32'd0);
      check("rst_number_valid", {31'd0, number_valid}, 32'd0);
      check("rst_number_bcd", {20'd0, number_bcd}, 32'd0);
      check("rst_op_valid", {31'd0, op_valid}, 32'd0);
      check("rst_op_code", {30'd0, op_code}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
   endtask

   initial begin
      exp_t e;
      reset  = 1'b1;
      sample = 4'hF;

      //            code   entry    cnt nv    nbcd     opv   opc    ov
      tbl[0]  = '{4'h1, 12'h001, 2'd1, 1'b0, 12'h000, 1'b0, 2'b00, 1'b0};
      tbl[1]  = '{4'h2, 12'h012, 2'd2, 1'b0, 12'h000, 1'b0, 2'b00, 1'b0};
      tbl[2]  = '{4'h3, 12'h123, 2'd3, 1'b0, 12'h000, 1'b0, 2'b00, 1'b0};
      tbl[3]  = '{4'hE, 12'h000, 2'd0, 1'b1, 12'h123, 1'b0, 2'b00, 1'b0};
      tbl[4]  = '{4'h9, 12'h009, 2'd1, 1'b0, 12'h123, 1'b0, 2'b00, 1'b0};
      tbl[5]  = '{4'h8, 12'h098, 2'd2, 1'b0, 12'h123, 1'b0, 2'b00, 1'b0};
      tbl[6]  = '{4'h7, 12'h987, 2'd3, 1'b0, 12'h123, 1'b0, 2'b00, 1'b0};
      tbl[7]  = '{4'h6, 12'h987, 2'd3, 1'b0, 12'h123, 1'b0, 2'b00, 1'b1};
      tbl[8]  = '{4'hD, 12'h000, 2'd0, 1'b0, 12'h123, 1'b0, 2'b00, 1'b0};
      tbl[9]  = '{4'h4, 12'h004, 2'd1, 1'b0, 12'h123, 1'b0, 2'b00, 1'b0};
      tbl[10] = '{4'h2, 12'h042, 2'd2, 1'b0, 12'h123, 1'b0, 2'b00, 1'b0};
      tbl[11] = '{4'hB, 12'h000, 2'd0, 1'b1, 12'h042, 1'b1, 2'b10, 1'b0};
      tbl[12] = '{4'hD, 12'h000, 2'd0, 1'b0, 12'h042, 1'b0, 2'b10, 1'b0};
      tbl[13] = '{4'hE, 12'h000, 2'd0, 1'b0, 12'h042, 1'b0, 2'b10, 1'b0};
      tbl[14] = '{4'hA, 12'h000, 2'd0, 1'b0, 12'h042, 1'b1, 2'b01, 1'b0};
      tbl[15] = '{4'h0, 12'h000, 2'd1, 1'b0, 12'h042, 1'b0, 2'b01, 1'b0};
      tbl[16] = '{4'h0, 12'h000, 2'd2, 1'b0, 12'h042, 1'b0, 2'b01, 1'b0};
      tbl[17] = '{4'h7, 12'h007, 2'd3, 1'b0, 12'h042, 1'b0, 2'b01, 1'b0};
      tbl[18] = '{4'hC, 12'h000, 2'd0, 1'b1, 12'h007, 1'b1, 2'b11, 1'b0};

      step(3);
      check_all_zero();
      reset = 1'b0;
      step(2);

      // First press: exact latency from sample change to strobe.
      q.push_back('{4'h5, 12'h005, 2'd1, 1'b0, 12'h000, 1'b0, 2'b00, 1'b0});
      sample    = 4'h5;
      drive_cyc = cyc;
      step(10);
      sample = 4'hF;
      step(10);
      check("strobe_consumed", q.size(), 0);
      check("press_latency", strobe_cyc - drive_cyc, 4);

      press('{4'hD, 12'h000, 2'd0, 1'b0, 12'h000, 1'b0, 2'b00, 1'b0});

      // Glitch one cycle short of qualification must be ignored.
      sample = 4'h7;
      step(3);
      sample = 4'hF;
      step(10);
      check("glitch_entry", {20'd0, entry_bcd}, 32'd0);
      check("glitch_count", {30'd0, digit_count}, 32'd0);

      for (int i = 0; i < 19; i++) press(tbl[i]);

      // Hold 3, roll to 6 without release: only 3 is accepted.
      q.push_back('{4'h3, 12'h003, 2'd1, 1'b0, 12'h007, 1'b0, 2'b11, 1'b0});
      sample = 4'h3;
      step(20);
      sample = 4'h6;
      step(20);
      check("hold_strobe_consumed", q.size(), 0);
      check("hold_key_code", {28'd0, key_code}, 32'h3);

      // Reset while 6 is still held; it must re-qualify and be accepted once.
      reset = 1'b1;
      step(2);
      check_all_zero();
      e = '{4'h6, 12'h006, 2'd1, 1'b0, 12'h000, 1'b0, 2'b00, 1'b0};
      q.push_back(e);
      reset = 1'b0;
      step(20);
      check("post_reset_consumed", q.size(), 0);
      sample = 4'hF;
      step(10);
      check("final_key_code", {28'd0, key_code}, 32'h6);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
